hough_frame_loader: RTL and testbench
=====================================

# hough_frame_loader

Parametrised front end for the Hough-transform accelerator. It latches a frame configuration (width, height, threshold) and accepts a valid/ready pixel stream. Pixels are written into `NUM_BANKS` interleaved BRAM banks with generated addresses. Once the last pixel has landed, it launches the Hough core with a one-cycle start pulse, waits for the core's `ready`, and reports completion. It replaces hand-driven BRAM loading and start/ready sequencing, and adds multi-bank interleave, configuration checking and abort.

## Interface
Parameters:
- `PIX_W`, 8: pixel width in bits.
- `DIM_W`, 9: width of the `width_i`/`height_i` fields.
- `NUM_BANKS`, 1: BRAM banks; must be a power of two (1, 2, 4, 8).
- `MAX_PIXELS`, 131072: BRAM capacity in pixels, summed over all banks.
- `ADDR_W` (localparam): `$clog2(MAX_PIXELS/NUM_BANKS)`; 17 at the defaults.

Ports:
- One clock `clk`; reset `rst` is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-low reset.
- `width_i`  in  DIM_W  frame width; sampled with `frame_start_i`.
- `height_i`  in  DIM_W  frame height; sampled with `frame_start_i`.
- `threshold_i`  in  8  vote threshold; sampled with `frame_start_i`.
- `frame_start_i`  in  1  single-cycle frame request.
- `abort_i`  in  1  synchronous abort.
- `s_valid_i`  in  1  pixel valid.
- `s_data_i`  in  PIX_W  pixel value.
- `s_ready_o`  out  1  pixel accept.
- `bram_addr_o`  out  ADDR_W  write address, shared by all banks.
- `bram_data_o`  out  PIX_W  write data.
- `bram_we_o`  out  NUM_BANKS  one-hot bank write enable.
- `threshold_o`  out  8  latched threshold, driven to the core.
- `core_start_o`  out  1  one-cycle core start.
- `core_ready_i`  in  1  core idle/finished.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  one-cycle configuration error pulse.

## Operation
- States: IDLE, LOAD, FLUSH, LAUNCH, WAIT_CORE.
- IDLE, on `frame_start_i`:
  - Latch width, height and threshold, and clear the counters.
  - If width==0, height==0, or width*height > MAX_PIXELS (product computed at 2*DIM_W bits): pulse `err_o` and stay in IDLE.
  - Otherwise go to LOAD.
- LOAD:
  - `s_ready_o`=1. Each beat with `s_valid_i`&&`s_ready_o` is one pixel, index p (0..N-1) in raster order.
  - Bank = p mod NUM_BANKS; address = p / NUM_BANKS (shift by log2 NUM_BANKS).
  - Internal col/row counters: col wraps at width-1, and row increments on the wrap.
  - Acceptance of p = N-1 moves to FLUSH.
- FLUSH: the final write is issued; `s_ready_o`=0. Go to LAUNCH.
- LAUNCH: `core_start_o`=1 for exactly one cycle. Go to WAIT_CORE.
- WAIT_CORE:
  - `core_ready_i` is ignored in the LAUNCH cycle.
  - The first cycle `core_ready_i`=1 in WAIT_CORE pulses `done_o` and returns to IDLE.
- `abort_i` in any non-IDLE state:
  - Next state is IDLE, and no further write, start or done is issued.
  - A write already registered still completes that cycle.
- `frame_start_i` outside IDLE is ignored. `abort_i` in IDLE is ignored. `abort_i` in the same cycle as `frame_start_i` in IDLE: abort wins and nothing is latched.
- `threshold_o` holds its value until the next accepted frame.

## Timing
- Reset values: all outputs 0, `bram_addr_o`=0, state IDLE, latched config 0.
- `s_ready_o` is combinational from the state (state==LOAD).
- All other outputs are registered.
- Write latency: a pixel accepted in cycle k appears on `bram_we_o`/`bram_addr_o`/`bram_data_o` in cycle k+1. `bram_we_o` is 0 in cycles with no acceptance.
- Last pixel accepted in cycle k: write in k+1 (FLUSH), `core_start_o` in k+2.
- `core_ready_i` is sampled from k+3 onward. `done_o` is asserted the cycle after `core_ready_i` is first seen high.
- `err_o` is asserted the cycle after `frame_start_i`.
- Back-to-back frames: `frame_start_i` is accepted in the cycle `done_o` is high, because the state is already IDLE.
- Reset asserted mid-frame clears everything immediately, including pending writes.

## Structure
- Package `hough_pkg`: state enum `loader_state_t`, default parameter constants, and the `$clog2`-derived width helpers.
- One sub-module: `hough_raster_counter` (col/row/pixel-index counter with clear, enable, last-pixel flag), reusable by the core's read side.

## Test plan
- Default params, 4x3 frame, pixels 0..11 streamed with no gaps: writes at addr 0..11 with data 0..11; `core_start_o` 2 cycles after the last accept; `core_ready_i` raised 5 cycles later gives `done_o` one cycle later.
- NUM_BANKS=4, 4x2 frame, pixels 0..7: `bram_we_o` cycles 0001,0010,0100,1000,0001,… with addr 0,0,0,0,1,1,1,1.
- Random `s_valid_i` gaps (50%) on a 9x7 frame: exactly 63 writes, no write in gap cycles, order preserved.
- width=0, and separately 512x512 with MAX_PIXELS=131072: `err_o` pulse, `busy_o` stays 0, no writes.
- `abort_i` after 5 of 16 pixels: returns to IDLE, no start; a new 2x2 frame then completes normally from addr 0.
- `rst` asserted during WAIT_CORE: all outputs 0 asynchronously; `done_o` is never asserted for that frame.

Source files
------------

// File: rtl/hough_pkg.sv
// Shared types and width helpers for the Hough frame loader.
// Holds the loader state enum and parameter defaults.
package hough_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_LAUNCH,
    S_WAIT
  } loader_state_t;

  localparam int DEF_PIX_W      = 8;
  localparam int DEF_DIM_W      = 9;
  localparam int DEF_NUM_BANKS  = 1;
  localparam int DEF_MAX_PIXELS = 131072;

  function automatic int addr_w(
    input int max_pixels,
    input int banks
  );
    return $clog2(max_pixels / banks);
  endfunction

  function automatic int idx_w(
    input int max_pixels
  );
    return (max_pixels <= 2) ? 1
         : $clog2(max_pixels);
  endfunction

  function automatic int bank_w(
    input int banks
  );
    return $clog2(banks);
  endfunction

endpackage

// File: rtl/hough_raster_counter.sv
// Raster-order pixel counter: col wraps at width-1, row steps on wrap.
// Ports: clk/rst, clr_i, en_i, width_i/height_i, idx_o (raster index), last_o.
module hough_raster_counter
  import hough_pkg::*;
#(
  parameter int DIM_W = DEF_DIM_W,
  parameter int IDX_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIM_W-1:0] width_i,
  input  logic [DIM_W-1:0] height_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             col_end;
  logic             row_end;

  assign col_end = (col_q == (width_i - ONE));
  assign row_end = (row_q == (height_i - ONE));
  assign last_o  = col_end && row_end;
  assign idx_o   = idx_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    idx_d = idx_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
      idx_d = '0;
    end else if (en_i) begin
      idx_d = idx_q + IDX_W'(1);
      if (col_end) begin
        col_d = '0;
        row_d = row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
      idx_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/hough_frame_loader.sv
// Hough front end: latches frame config, loads pixels into interleaved banks,
// then pulses core start and waits for core ready. Ports: config, stream, BRAM, core.
module hough_frame_loader
  import hough_pkg::*;
#(
  parameter  int PIX_W      = DEF_PIX_W,
  parameter  int DIM_W      = DEF_DIM_W,
  parameter  int NUM_BANKS  = DEF_NUM_BANKS,
  parameter  int MAX_PIXELS = DEF_MAX_PIXELS,
  localparam int ADDR_W     = addr_w(MAX_PIXELS, NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIM_W-1:0]     width_i,
  input  logic [DIM_W-1:0]     height_i,
  input  logic [7:0]           threshold_i,
  input  logic                 frame_start_i,
  input  logic                 abort_i,
  input  logic                 s_valid_i,
  input  logic [PIX_W-1:0]     s_data_i,
  output logic                 s_ready_o,
  output logic [ADDR_W-1:0]    bram_addr_o,
  output logic [PIX_W-1:0]     bram_data_o,
  output logic [NUM_BANKS-1:0] bram_we_o,
  output logic [7:0]           threshold_o,
  output logic                 core_start_o,
  input  logic                 core_ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int IDX_W  = idx_w(MAX_PIXELS);
  localparam int BANK_W = bank_w(NUM_BANKS);

  loader_state_t state_q, state_d;

  logic [DIM_W-1:0]     width_q, width_d;
  logic [DIM_W-1:0]     height_q, height_d;
  logic [7:0]           thr_q, thr_d;
  logic [NUM_BANKS-1:0] we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [PIX_W-1:0]     data_q, data_d;
  logic                 start_q, start_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [2*DIM_W-1:0]   area;
  logic                 cfg_bad;
  logic                 accept;
  logic                 take;
  logic                 cnt_clr;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     bank_sel;
  logic                 last_pix;

  assign area = {{DIM_W{1'b0}}, width_i}
              * {{DIM_W{1'b0}}, height_i};

  assign cfg_bad = (width_i == '0)
                || (height_i == '0)
                || (64'(area) > 64'(MAX_PIXELS));

  assign s_ready_o = (state_q == S_LOAD);
  assign accept    = s_ready_o && s_valid_i;
  // an aborted beat is handshaken but never written
  assign take      = accept && !abort_i;
  assign cnt_clr   = (state_q == S_IDLE)
                  && frame_start_i && !abort_i;
  assign bank_sel  = idx & IDX_W'(NUM_BANKS - 1);

  hough_raster_counter #(
    .DIM_W (DIM_W),
    .IDX_W (IDX_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .en_i     (take),
    .width_i  (width_q),
    .height_i (height_q),
    .idx_o    (idx),
    .last_o   (last_pix)
  );

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    thr_d    = thr_q;
    we_d     = '0;
    addr_d   = addr_q;
    data_d   = data_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_start_i && !abort_i) begin
          width_d  = width_i;
          height_d = height_i;
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            thr_d   = threshold_i;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (accept) begin
          we_d   = NUM_BANKS'(1) << bank_sel;
          addr_d = ADDR_W'(idx >> BANK_W);
          data_d = s_data_i;
          if (last_pix) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          start_d = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = abort_i ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (core_ready_i) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      width_q  <= '0;
      height_q <= '0;
      thr_q    <= '0;
      we_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      thr_q    <= thr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      start_q  <= start_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bram_we_o    = we_q;
  assign bram_addr_o  = addr_q;
  assign bram_data_o  = data_q;
  assign threshold_o  = thr_q;
  assign core_start_o = start_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_hough_frame_loader.sv
// Randomized directed bench for hough_frame_loader (4 banks).
// Expected writes and timing come from a pixel-list model in the bench.
module tb_hough_frame_loader;

  localparam int PIX_W  = 8;
  localparam int DIM_W  = 10;
  localparam int NB     = 4;
  localparam int MAXP   = 131072;
  localparam int ADDR_W = $clog2(MAXP / NB);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DIM_W-1:0]  width_i = '0;
  logic [DIM_W-1:0]  height_i = '0;
  logic [7:0]        threshold_i = '0;
  logic              frame_start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic              s_valid_i = 1'b0;
  logic [PIX_W-1:0]  s_data_i = '0;
  logic              s_ready_o;
  logic [ADDR_W-1:0] bram_addr_o;
  logic [PIX_W-1:0]  bram_data_o;
  logic [NB-1:0]     bram_we_o;
  logic [7:0]        threshold_o;
  logic              core_start_o;
  logic              core_ready_i = 1'b0;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  hough_frame_loader #(
    .PIX_W      (PIX_W),
    .DIM_W      (DIM_W),
    .NUM_BANKS  (NB),
    .MAX_PIXELS (MAXP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .width_i       (width_i),
    .height_i      (height_i),
    .threshold_i   (threshold_i),
    .frame_start_i (frame_start_i),
    .abort_i       (abort_i),
    .s_valid_i     (s_valid_i),
    .s_data_i      (s_data_i),
    .s_ready_o     (s_ready_o),
    .bram_addr_o   (bram_addr_o),
    .bram_data_o   (bram_data_o),
    .bram_we_o     (bram_we_o),
    .threshold_o   (threshold_o),
    .core_start_o  (core_start_o),
    .core_ready_i  (core_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  int wq_we[$];
  int wq_addr[$];
  int wq_data[$];
  int exp_data[$];
  int start_cnt, start_cyc;
  int done_cnt, done_cyc;
  int err_cnt, err_cyc;
  int busy_cnt;

  always @(negedge clk) begin
    if (bram_we_o != '0) begin
      wq_we.push_back(int'(bram_we_o));
      wq_addr.push_back(int'(bram_addr_o));
      wq_data.push_back(int'(bram_data_o));
    end
    if (core_start_o) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_o) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (busy_o) busy_cnt++;
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wq_we.delete();
    wq_addr.delete();
    wq_data.delete();
    exp_data.delete();
    start_cnt = 0;
    done_cnt  = 0;
    err_cnt   = 0;
    busy_cnt  = 0;
    start_cyc = -1;
    done_cyc  = -1;
    err_cyc   = -1;
  endtask

  task automatic kick(
    input int w, input int h,
    input int thr, input bit ab
  );
    width_i       = DIM_W'(w);
    height_i      = DIM_W'(h);
    threshold_i   = 8'(thr);
    frame_start_i = 1'b1;
    abort_i       = ab;
    @(posedge clk); #1;
    frame_start_i = 1'b0;
    abort_i       = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // compare captured writes against the expected pixel list
  task automatic chk_writes(input string tag);
    int n;
    chk({tag, ".nwr"}, 64'(wq_data.size()),
        64'(exp_data.size()));
    n = (wq_data.size() < exp_data.size())
      ? wq_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, ".we"},   64'(wq_we[i]),   64'(1 << (i % NB)));
      chk({tag, ".addr"}, 64'(wq_addr[i]), 64'(i / NB));
      chk({tag, ".data"}, 64'(wq_data[i]), 64'(exp_data[i]));
    end
  endtask

  // gap: % of idle cycles; abort_at<0 means none;
  // rdy<0 holds core_ready high from the start
  task automatic run_frame(
    input string tag,
    input int w, input int h, input int thr,
    input int gap, input bit seq,
    input int abort_at, input int rdy
  );
    int p, n, last_e, r, guard;
    bit v;
    logic [PIX_W-1:0] d;
    clear_mon();
    n = w * h;
    p = 0;
    last_e = -1;
    guard = 0;
    if (rdy < 0) core_ready_i = 1'b1;
    kick(w, h, thr, 1'b0);
    while (p < n && guard < 5000) begin
      guard++;
      d = seq ? PIX_W'(p) : PIX_W'($urandom_range(255));
      if (p == abort_at) begin
        s_valid_i = 1'b1;
        s_data_i  = d;
        abort_i   = 1'b1;
        tick(1);
        abort_i   = 1'b0;
        s_valid_i = 1'b0;
        break;
      end
      v = ($urandom_range(99) >= gap);
      s_valid_i = v;
      s_data_i  = d;
      tick(1);
      if (v) begin
        exp_data.push_back(int'(d));
        last_e = cyc;
        p++;
      end
    end
    s_valid_i = 1'b0;
    if (abort_at >= 0) begin
      tick(8);
      chk({tag, ".nostart"}, 64'(start_cnt), 64'd0);
      chk({tag, ".idle"}, 64'(busy_o), 64'd0);
      chk_writes(tag);
      return;
    end
    for (int i = 0; i < 20 && start_cnt == 0; i++) tick(1);
    chk({tag, ".start"}, 64'(start_cnt), 64'd1);
    chk({tag, ".start_t"}, 64'(start_cyc), 64'(last_e + 1));
    if (rdy >= 0) begin
      tick(rdy);
      core_ready_i = 1'b1;
      r = cyc;
    end else begin
      r = last_e + 2;
    end
    for (int i = 0; i < 40 && done_cnt == 0; i++) tick(1);
    core_ready_i = 1'b0;
    chk({tag, ".done"}, 64'(done_cnt), 64'd1);
    chk({tag, ".done_t"}, 64'(done_cyc), 64'(r + 1));
    chk({tag, ".busy"}, 64'(busy_o), 64'd0);
    chk({tag, ".thr"}, 64'(threshold_o), 64'(thr));
    chk({tag, ".one_start"}, 64'(start_cnt), 64'd1);
    chk_writes(tag);
  endtask

  initial begin
    clear_mon();
    #12;
    chk("rst.outs",
        64'({s_ready_o, core_start_o, busy_o, done_o, err_o,
             bram_we_o, bram_addr_o, bram_data_o, threshold_o}),
        64'd0);
    rst = 1'b1;
    tick(2);

    run_frame("f4x3", 4, 3, 8'h5a, 0, 1'b1, -1, 5);
    run_frame("f4x2", 4, 2, 8'h11, 0, 1'b1, -1, 0);
    run_frame("f9x7", 9, 7, 8'hc3, 50, 1'b0, -1, 3);
    run_frame("fhold", 3, 3, 8'h22, 20, 1'b0, -1, -1);

    clear_mon();
    kick(0, 5, 8'h77, 1'b0);
    tick(3);
    chk("w0.err", 64'(err_cnt), 64'd1);
    chk("w0.err_t", 64'(err_cyc), 64'(cyc - 3));
    chk("w0.busy", 64'(busy_cnt), 64'd0);
    chk("w0.nwr", 64'(wq_data.size()), 64'd0);

    clear_mon();
    kick(512, 512, 8'h77, 1'b0);
    tick(3);
    chk("big.err", 64'(err_cnt), 64'd1);
    chk("big.busy", 64'(busy_cnt), 64'd0);
    chk("big.thr", 64'(threshold_o), 64'h22);

    clear_mon();
    kick(512, 256, 8'h33, 1'b0);
    chk("edge.busy", 64'(busy_o), 64'd1);
    chk("edge.rdy", 64'(s_ready_o), 64'd1);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    tick(2);
    chk("edge.err", 64'(err_cnt), 64'd0);
    chk("edge.abort", 64'(busy_o), 64'd0);

    clear_mon();
    kick(3, 3, 8'h99, 1'b1);
    tick(3);
    chk("abst.busy", 64'(busy_cnt), 64'd0);
    chk("abst.err", 64'(err_cnt), 64'd0);
    chk("abst.thr", 64'(threshold_o), 64'h33);

    run_frame("abort", 4, 4, 8'h44, 0, 1'b0, 5, 0);
    run_frame("f2x2", 2, 2, 8'h45, 0, 1'b0, -1, 1);

    clear_mon();
    kick(3, 2, 8'h66, 1'b0);
    for (int i = 0; i < 6; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = PIX_W'(i + 1);
      tick(1);
    end
    s_valid_i = 1'b0;
    tick(4);
    chk("rstw.start", 64'(start_cnt), 64'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("rstw.outs",
        64'({s_ready_o, core_start_o, busy_o, done_o, err_o,
             bram_we_o, bram_addr_o, bram_data_o, threshold_o}),
        64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    core_ready_i = 1'b1;
    tick(5);
    core_ready_i = 1'b0;
    chk("rstw.nodone", 64'(done_cnt), 64'd0);
    chk("rstw.busy", 64'(busy_o), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
